// File: rtl/img_pkg.sv
// img_pkg: shared image defaults (pixel width, frame size) and the stream FSM state type
package img_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_HEIGHT = 5;
  typedef enum logic [1:0] {IDLE, LEAD, STREAM, DONE} stream_state_t;
endpackage

// File: rtl/frame_ram.sv
// frame_ram: DEPTH x DW frame store; ports clk, we/wr_addr/wr_data write port, rd_addr -> rd_data registered read, no reset
module frame_ram #(
  parameter int DEPTH = 20,
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: replays a buffered frame as lead cycle, raster pixel stream, done pulse; ports clk, rst, wr_en/wr_addr/wr_data, start, hold -> enable, pixel_out, last, busy, done
module pixel_streamer import img_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PIX_W = DEF_PIX_W,
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              hold,
  output logic              enable,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              last,
  output logic              busy,
  output logic              done
);
  localparam int N = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  stream_state_t state, state_n;
  logic [ADDR_W-1:0] cur, cur_n, rd_addr;
  logic stall, stall_n;
  logic [PIX_W-1:0] rd_data, pix_q;
  assign busy = state == LEAD || state == STREAM;
  assign done = state == DONE;
  assign enable = busy && !stall;
  assign last = state == STREAM && cur == LAST;
  assign pixel_out = state != STREAM ? '0 : stall ? pix_q : rd_data;
  // cur is the last pixel shown; always prefetch the one after it so a resume needs no extra cycle
  assign rd_addr = (state == STREAM && cur != LAST) ? cur + ADDR_W'(1) : '0;
  frame_ram #(.DEPTH(N), .AW(ADDR_W), .DW(PIX_W)) u_ram (
    .clk(clk),
    .we(wr_en && !busy && wr_addr <= LAST),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always_comb begin
    state_n = state == IDLE ? (start ? LEAD : IDLE) :
              state == DONE ? IDLE :
              hold ? state :
              state == LEAD ? STREAM :
              last ? DONE : STREAM;
    stall_n = busy && hold;
    cur_n = (!busy || hold) ? cur : state == LEAD ? '0 : cur + ADDR_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      stall <= 1'b0;
      pix_q <= '0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      stall <= stall_n;
      pix_q <= pixel_out;
    end
  end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: directed self-checking bench for pixel_streamer (4x5 frame, 8-bit pixels)
module tb_pixel_streamer;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, hold = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0, pixel_out;
  logic enable, last, busy, done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pixel_streamer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .hold(hold), .enable(enable), .pixel_out(pixel_out),
    .last(last), .busy(busy), .done(done)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic e, input logic [7:0] p, input logic l, input logic b, input logic d);
    total++;
    assert ({enable, pixel_out, last, busy, done} === {e, p, l, b, d}) else begin
      bad++;
      $error("FAIL %s observed en=%b px=%0d last=%b busy=%b done=%b expected en=%b px=%0d last=%b busy=%b done=%b",
             tag, enable, pixel_out, last, busy, done, e, p, l, b, d);
    end
  endtask
  function automatic logic [7:0] pix(input int k, input logic [7:0] p0);
    return k == 0 ? p0 : 8'(10 * (k + 1));
  endfunction
  // One full frame: start pulse, lead, 20 pixels (optional hold after pixel hk, optional busy write/start at k=1), done, idle
  task automatic frame(input string tag, input logic [7:0] p0, input int hk, input int hlen, input bit inj, input bit keep);
    start = 1'b1;
    tick;
    start = keep;
    wr_en = 1'b0;
    chk({tag, "_lead"}, 1, 8'd0, 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      tick;
      start = keep;
      wr_en = 1'b0;
      chk($sformatf("%s_px%0d", tag, k), 1, pix(k, p0), k == 19, 1, 0);
      if (inj && k == 1) begin
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'hFF;
        start = 1'b1;
      end
      if (k == hk) begin
        hold = 1'b1;
        for (int j = 0; j < hlen; j++) begin
          tick;
          if (j == hlen - 1) hold = 1'b0;
          chk($sformatf("%s_stall%0d", tag, j), 0, pix(k, p0), k == 19, 1, 0);
        end
      end
    end
    tick;
    chk({tag, "_done"}, 0, 8'd0, 0, 0, 1);
    tick;
    chk({tag, "_idle"}, 0, 8'd0, 0, 0, 0);
  endtask
  initial begin
    tick;
    tick;
    chk("reset", 0, 8'd0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_addr = 5'(i);
      wr_data = 8'(10 * (i + 1));
      tick;
    end
    wr_en = 1'b0;
    chk("loaded_idle", 0, 8'd0, 0, 0, 0);
    frame("basic", 8'd10, -1, 0, 1'b0, 1'b0);
    frame("hold", 8'd10, 4, 3, 1'b0, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("r_lead", 1, 8'd0, 0, 1, 0);
    for (int k = 0; k < 8; k++) tick;
    chk("r_px80", 1, 8'd80, 0, 1, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid", 0, 8'd0, 0, 0, 0);
    tick;
    chk("rst_nodone", 0, 8'd0, 0, 0, 0);
    frame("after_rst", 8'd10, -1, 0, 1'b0, 1'b0);
    frame("busy_inj", 8'd10, -1, 0, 1'b1, 1'b0);
    frame("post_inj", 8'd10, -1, 0, 1'b0, 1'b0);
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 8'h55;
    frame("wr_start", 8'h55, -1, 0, 1'b0, 1'b0);
    wr_en = 1'b1;
    wr_addr = 5'd25;
    wr_data = 8'hAA;
    tick;
    wr_en = 1'b0;
    frame("oob", 8'h55, -1, 0, 1'b0, 1'b0);
    frame("b2b1", 8'h55, -1, 0, 1'b0, 1'b1);
    frame("b2b2", 8'h55, -1, 0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
